mem_port_arbiter: RTL and testbench

//  Shares the single 32-bit memory port between instruction fetch (IF) and the load/store stage (MEM).

---
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store,
// data side first, with a starvation counter that forces a fetch grant.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  input  logic            if_kill_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [2:0]      d_len_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [2:0]      mem_len_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_e;
  state_e          state_q;
  logic [CW-1:0]   starve_q, starve_d;
  logic            we_q, illegal_q, kill_q, if_rvalid_q, d_rvalid_q;
  logic [2:0]      len_q;
  logic [XLEN-1:0] addr_q, wdata_q, if_rdata_q, d_rdata_q;
  logic            idle, grant_if, grant_d, len_ok, if_done, d_done, kill_now;
  assign idle     = state_q == IDLE;
  assign grant_if = rst_n_i && idle && if_req_i && (!d_req_i || starve_q == SMAX);
  assign grant_d  = rst_n_i && idle && d_req_i && !grant_if;
  assign len_ok   = d_len_i inside {3'd1, 3'd2, 3'd4};
  assign if_done  = state_q == BUSY_IF && mem_ack_i;
  // an illegal-length access never reaches memory and retires on its own
  assign d_done   = state_q == BUSY_D && (illegal_q || mem_ack_i);
  assign kill_now = kill_q || if_kill_i;
  assign starve_d = (!if_req_i || grant_if) ? '0 :
                    (grant_d && starve_q != SMAX) ? starve_q + CW'(1) : starve_q;
  assign if_gnt_o    = grant_if;
  assign d_gnt_o     = grant_d;
  assign if_rvalid_o = if_rvalid_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_req_o   = state_q == BUSY_IF || (state_q == BUSY_D && !illegal_q);
  assign mem_we_o    = we_q;
  assign mem_len_o   = len_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      we_q        <= 1'b0;
      illegal_q   <= 1'b0;
      kill_q      <= 1'b0;
      len_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      starve_q    <= starve_d;
      if_rvalid_q <= if_done && !kill_now;
      d_rvalid_q  <= d_done;
      if (if_done && !kill_now) if_rdata_q <= mem_rdata_i;
      if (d_done) d_rdata_q <= (we_q || illegal_q) ? '0 : mem_rdata_i;
      if (grant_if) begin
        state_q   <= BUSY_IF;
        we_q      <= 1'b0;
        len_q     <= 3'd4;
        addr_q    <= if_addr_i;
        wdata_q   <= '0;
        illegal_q <= 1'b0;
        kill_q    <= 1'b0;
      end else if (grant_d) begin
        state_q   <= BUSY_D;
        we_q      <= d_we_i;
        len_q     <= d_len_i;
        addr_q    <= d_addr_i;
        wdata_q   <= d_wdata_i;
        illegal_q <= !len_ok;
        kill_q    <= 1'b0;
      end else if (if_done || d_done) begin
        state_q <= IDLE;
        kill_q  <= 1'b0;
      end else if (state_q == BUSY_IF && if_kill_i) begin
        kill_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed cycle-by-cycle checks of arbitration, latency,
// starvation, store, kill, illegal length and async reset.
module tb_mem_port_arbiter;
  logic        clk_i = 1'b0, rst_n_i = 1'b0;
  logic        if_req_i = 0, if_kill_i = 0, d_req_i = 0, d_we_i = 0, mem_ack_i = 0;
  logic [31:0] if_addr_i = 0, d_addr_i = 0, d_wdata_i = 0, mem_rdata_i = 0;
  logic [2:0]  d_len_i = 0;
  logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_req_o, mem_we_o;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic [2:0]  mem_len_o;
  int          n_chk = 0, n_pass = 0;
  logic        auto_ack = 0;

  mem_port_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_len_i(d_len_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_len_o(mem_len_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  // inputs change just after the rising edge; a zero-wait memory acks in the same cycle
  task automatic tick;
    @(posedge clk_i);
    #1;
    if (auto_ack) mem_ack_i = mem_req_o;
  endtask

  task automatic settle;
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g[6];
    int   n;
    logic last_if;
    logic exp_g[6];
    exp_g = '{0, 0, 0, 0, 1, 0};
    tick; tick; settle;
    chk("rst_mem_req", 32'(mem_req_o), 0);
    chk("rst_gnt", {30'b0, if_gnt_o, d_gnt_o}, 0);
    chk("rst_rvalid", {30'b0, if_rvalid_o, d_rvalid_o}, 0);
    chk("rst_addr", mem_addr_o, 0);
    tick; rst_n_i = 1;
    // 1: single fetch, zero-wait memory
    tick; if_req_i = 1; if_addr_i = 32'h8000_0000; settle;
    chk("t1_if_gnt", 32'(if_gnt_o), 1);
    chk("t1_d_gnt", 32'(d_gnt_o), 0);
    tick; if_req_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h0000_0013; settle;
    chk("t1_mem_req", 32'(mem_req_o), 1);
    chk("t1_mem_addr", mem_addr_o, 32'h8000_0000);
    chk("t1_mem_len", 32'(mem_len_o), 4);
    chk("t1_mem_we", 32'(mem_we_o), 0);
    chk("t1_early_rvalid", 32'(if_rvalid_o), 0);
    tick; mem_ack_i = 0; settle;
    chk("t1_rvalid", 32'(if_rvalid_o), 1);
    chk("t1_rdata", if_rdata_o, 32'h0000_0013);
    chk("t1_mem_req_off", 32'(mem_req_o), 0);
    tick; settle;
    chk("t1_rvalid_pulse", 32'(if_rvalid_o), 0);
    chk("t1_rdata_hold", if_rdata_o, 32'h0000_0013);
    // 2: simultaneous requests, data first, fetch granted back-to-back
    tick; if_req_i = 1; if_addr_i = 32'h0000_1000;
    d_req_i = 1; d_we_i = 0; d_len_i = 4; d_addr_i = 32'h100; settle;
    chk("t2_d_gnt", 32'(d_gnt_o), 1);
    chk("t2_if_gnt", 32'(if_gnt_o), 0);
    tick; d_req_i = 0; mem_ack_i = 1; mem_rdata_i = 32'hCAFE_F00D; settle;
    chk("t2_mem_addr_d", mem_addr_o, 32'h100);
    chk("t2_if_gnt_busy", 32'(if_gnt_o), 0);
    tick; mem_ack_i = 0; settle;
    chk("t2_d_rvalid", 32'(d_rvalid_o), 1);
    chk("t2_d_rdata", d_rdata_o, 32'hCAFE_F00D);
    chk("t2_if_gnt_b2b", 32'(if_gnt_o), 1);
    tick; if_req_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h1111_1111; settle;
    chk("t2_mem_addr_if", mem_addr_o, 32'h0000_1000);
    tick; mem_ack_i = 0; settle;
    chk("t2_if_rvalid", 32'(if_rvalid_o), 1);
    chk("t2_if_rdata", if_rdata_o, 32'h1111_1111);
    // 3: starvation limit forces a fetch after four data grants
    tick; d_req_i = 1; d_len_i = 4; d_addr_i = 32'h200; if_req_i = 1; if_addr_i = 32'h2000;
    mem_rdata_i = 32'h7777_7777; auto_ack = 1;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      settle;
      last_if = if_gnt_o;
      if (d_gnt_o) begin g[n] = 0; n++; end
      else if (if_gnt_o) begin g[n] = 1; n++; end
      tick;
      if (last_if) if_req_i = 0;
      if (n == 6) d_req_i = 0;
    end
    chk("t3_grants", 32'(n), 6);
    for (int i = 0; i < n; i++) chk($sformatf("t3_grant%0d", i), 32'(g[i]), 32'(exp_g[i]));
    tick; tick; auto_ack = 0; mem_ack_i = 0;
    settle;
    chk("t3_d_rdata", d_rdata_o, 32'h7777_7777);
    // 6a: illegal length completes internally with zero data
    tick; d_req_i = 1; d_we_i = 0; d_len_i = 3; d_addr_i = 32'h400; settle;
    chk("t6_d_gnt", 32'(d_gnt_o), 1);
    tick; d_req_i = 0; mem_ack_i = 0; settle;
    chk("t6_no_mem_req", 32'(mem_req_o), 0);
    chk("t6_early_rvalid", 32'(d_rvalid_o), 0);
    tick; settle;
    chk("t6_rvalid", 32'(d_rvalid_o), 1);
    chk("t6_rdata", d_rdata_o, 0);
    // 4: byte store with a 3-cycle ack delay
    tick; d_req_i = 1; d_we_i = 1; d_len_i = 1; d_addr_i = 32'h203; d_wdata_i = 32'hAABB_CCDD; settle;
    chk("t4_d_gnt", 32'(d_gnt_o), 1);
    for (int i = 0; i < 3; i++) begin
      tick; d_req_i = 0; mem_ack_i = (i == 2); mem_rdata_i = 32'hDEAD_BEEF; settle;
      chk($sformatf("t4_req%0d", i), {29'b0, mem_req_o, mem_we_o, d_rvalid_o}, 32'b110);
      chk($sformatf("t4_len%0d", i), 32'(mem_len_o), 1);
      chk($sformatf("t4_addr%0d", i), mem_addr_o, 32'h203);
      chk($sformatf("t4_wdata%0d", i), mem_wdata_o, 32'hAABB_CCDD);
    end
    tick; mem_ack_i = 0; settle;
    chk("t4_rvalid", 32'(d_rvalid_o), 1);
    chk("t4_rdata", d_rdata_o, 0);
    tick; settle;
    chk("t4_rvalid_once", 32'(d_rvalid_o), 0);
    chk("t4_idle", 32'(mem_req_o), 0);
    // 5: killed fetch consumes its ack silently, next fetch returns normally
    tick; d_we_i = 0; if_req_i = 1; if_addr_i = 32'h3000; settle;
    chk("t5_gnt", 32'(if_gnt_o), 1);
    tick; if_req_i = 0; if_kill_i = 1; settle;
    chk("t5_mem_req", 32'(mem_req_o), 1);
    tick; if_kill_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h55; settle;
    chk("t5_mem_req_held", 32'(mem_req_o), 1);
    tick; mem_ack_i = 0; settle;
    chk("t5_no_rvalid", 32'(if_rvalid_o), 0);
    chk("t5_rdata_hold", if_rdata_o, 32'h7777_7777);
    tick; if_req_i = 1; if_addr_i = 32'h3004; settle;
    chk("t5_gnt2", 32'(if_gnt_o), 1);
    tick; if_req_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h66; settle;
    chk("t5_addr2", mem_addr_o, 32'h3004);
    tick; mem_ack_i = 0; settle;
    chk("t5_rvalid2", 32'(if_rvalid_o), 1);
    chk("t5_rdata2", if_rdata_o, 32'h66);
    // 6b: asynchronous reset during a data access
    tick; d_req_i = 1; d_len_i = 4; d_addr_i = 32'h500; settle;
    chk("t6b_gnt", 32'(d_gnt_o), 1);
    tick; d_req_i = 0; settle;
    chk("t6b_mem_req", 32'(mem_req_o), 1);
    #1 rst_n_i = 0;
    #1;
    chk("t6b_rst_req", 32'(mem_req_o), 0);
    chk("t6b_rst_addr", mem_addr_o, 0);
    chk("t6b_rst_rdata", if_rdata_o | d_rdata_o, 0);
    chk("t6b_rst_pulses", {28'b0, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o}, 0);
    tick; mem_ack_i = 1; settle;
    chk("t6b_rst_no_rvalid", 32'(d_rvalid_o), 0);
    tick; rst_n_i = 1; mem_ack_i = 0; settle;
    chk("t6b_after_rvalid", 32'(d_rvalid_o), 0);
    chk("t6b_after_req", 32'(mem_req_o), 0);
    tick; settle;
    chk("t6b_after_rvalid2", 32'(d_rvalid_o), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
